// File: rtl/uob_pq_pkg.sv
// Shared definitions for the unit output buffer packet queue: marker word,
// default queue size, read FSM encoding and a width helper.
package uob_pq_pkg;

  localparam logic [63:0] UOB_PQ_HDR       = '1;
  localparam int          UOB_PQ_QUEUE_MSB = 2;
  localparam int          UOB_PQ_N_THREADS = 8;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_OFFER,
    RD_HDR,
    RD_TID,
    RD_DATA,
    RD_TERM
  } rd_state_e;

  // Index of the highest set bit needed to represent x (at least 0).
  function automatic int msb(input int x);
    return (x < 2) ? 0 : $clog2(x + 1) - 1;
  endfunction

endpackage

// File: rtl/asymm_bram_min_rd.sv
// Block RAM with a wide write port and a narrow registered read port.
// Narrow slice 0 of each wide word is its least significant slice.
module asymm_bram_min_rd #(
  parameter  int MIN_WIDTH = 8,
  parameter  int RATIO     = 2,
  parameter  int MAX_DEPTH = 256,
  localparam int MAX_WIDTH = MIN_WIDTH * RATIO,
  localparam int WA_W      = $clog2(MAX_DEPTH),
  localparam int SEL_W     = $clog2(RATIO),
  localparam int RA_W      = WA_W + SEL_W
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [WA_W-1:0]      wr_addr_i,
  input  logic [MAX_WIDTH-1:0] din_i,
  input  logic                 rd_en_i,
  input  logic [RA_W-1:0]      rd_addr_i,
  output logic [MIN_WIDTH-1:0] dout_o
);

  logic [MAX_WIDTH-1:0] mem [MAX_DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= din_i;
  end

  generate
    if (RATIO == 1) begin : g_same
      always_ff @(posedge clk_i) begin
        if (rd_en_i) dout_o <= mem[rd_addr_i];
      end
    end else begin : g_asym
      logic [MAX_WIDTH-1:0] word;
      assign word = mem[rd_addr_i[RA_W-1:SEL_W]];
      always_ff @(posedge clk_i) begin
        if (rd_en_i) dout_o <= word[rd_addr_i[SEL_W-1:0]*MIN_WIDTH +: MIN_WIDTH];
      end
    end
  endgenerate

endmodule

// File: rtl/uob_pq.sv
// Unit output buffer: CPU writes whole packets into queue slots, the read FSM
// streams them out as header, thread ID, data slices and a zero terminator.
module uob_pq import uob_pq_pkg::*; #(
  parameter  int IN_WIDTH      = 16,
  parameter  int OUT_WIDTH     = 8,
  parameter  int MAX_PKT_LEN   = 20,
  parameter  int ADDR_MSB      = msb(MAX_PKT_LEN - 1),
  parameter  int PKT_QUEUE_MSB = UOB_PQ_QUEUE_MSB,
  parameter  int N_THREADS     = UOB_PQ_N_THREADS,
  localparam int TID_MSB       = msb(N_THREADS - 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_WIDTH-1:0]      din,
  input  logic                     wr_en,
  input  logic [ADDR_MSB:0]        wr_addr,
  input  logic [TID_MSB:0]         wr_tid,
  input  logic                     set_input_complete,
  input  logic                     set_input_abort,
  output logic                     ready,
  output logic                     full,
  output logic [PKT_QUEUE_MSB+1:0] n_free,
  output logic [OUT_WIDTH-1:0]     dout,
  input  logic                     rd_en,
  output logic                     empty
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int RSH   = $clog2(RATIO);
  localparam int QW    = PKT_QUEUE_MSB + 1;
  localparam int CW    = QW + 1;
  localparam int DEPTH = 1 << QW;
  localparam int AW    = ADDR_MSB + 1;
  localparam int LW    = AW + 1;
  localparam int SLW   = LW + RSH;
  localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
  localparam logic [OUT_WIDTH-1:0] HDR     = UOB_PQ_HDR[OUT_WIDTH-1:0];

  logic [QW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               in_progress_q, in_progress_d;
  logic [TID_MSB:0]   tid_q, tid_d, tid_upd;
  logic [LW-1:0]      len_q, len_d, len_upd, wlen;
  logic               ready_q, full_q;
  logic [CW-1:0]      n_free_q;
  logic               wr_acc, push, pop;

  logic [TID_MSB:0]   tid_mem [DEPTH];
  logic [LW-1:0]      len_mem [DEPTH];

  rd_state_e          state_q;
  logic [OUT_WIDTH-1:0] dout_q, bram_q;
  logic               empty_q;
  logic [SLW-1:0]     slice_q, term_at;
  logic [LW-1:0]      cur_len;
  logic [TID_MSB:0]   cur_tid;

  assign wr_acc  = wr_en & ~full_q;
  assign pop     = (state_q == RD_TERM);
  // A full queue can still take a complete in the cycle its head slot is popped.
  assign push    = set_input_complete & ~set_input_abort & (~full_q | pop);
  assign wlen    = LW'(wr_addr) + LW'(1);
  assign len_upd = (wr_acc && (wlen > len_q)) ? wlen : len_q;
  assign tid_upd = in_progress_q ? tid_q : wr_tid;

  always_comb begin
    in_progress_d = in_progress_q | wr_acc;
    tid_d         = wr_acc ? tid_upd : tid_q;
    len_d         = len_upd;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (set_input_abort || push) begin
      in_progress_d = 1'b0;
      len_d         = '0;
    end
    if (push) wr_ptr_d = wr_ptr_q + QW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      count_q       <= '0;
      in_progress_q <= 1'b0;
      tid_q         <= '0;
      len_q         <= '0;
      ready_q       <= 1'b1;
      full_q        <= 1'b0;
      n_free_q      <= DEPTH_C;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      in_progress_q <= in_progress_d;
      tid_q         <= tid_d;
      len_q         <= len_d;
      ready_q       <= ~in_progress_d & (count_d < DEPTH_C);
      full_q        <= (count_d == DEPTH_C);
      n_free_q      <= DEPTH_C - count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tid_mem[wr_ptr_q] <= tid_upd;
      len_mem[wr_ptr_q] <= len_upd;
    end
  end

  assign cur_len = len_mem[rd_ptr_q];
  assign cur_tid = tid_mem[rd_ptr_q];
  assign term_at = (SLW'(cur_len) << RSH) + SLW'(1);

  // slice_q runs one slice ahead of dout to hide the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RD_IDLE;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      rd_ptr_q <= '0;
      slice_q  <= '0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          slice_q <= '0;
          if (count_q != '0) begin
            state_q <= RD_OFFER;
            empty_q <= 1'b0;
          end
        end
        RD_OFFER: begin
          slice_q <= '0;
          if (rd_en) begin
            state_q <= RD_HDR;
            empty_q <= 1'b1;
            dout_q  <= HDR;
          end
        end
        RD_HDR: begin
          dout_q  <= OUT_WIDTH'(cur_tid);
          slice_q <= slice_q + SLW'(1);
          state_q <= RD_TID;
        end
        RD_TID: begin
          if (cur_len == '0) begin
            dout_q  <= '0;
            state_q <= RD_TERM;
          end else begin
            dout_q  <= bram_q;
            slice_q <= slice_q + SLW'(1);
            state_q <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (slice_q == term_at) begin
            dout_q  <= '0;
            state_q <= RD_TERM;
          end else begin
            dout_q  <= bram_q;
            slice_q <= slice_q + SLW'(1);
          end
        end
        RD_TERM: begin
          dout_q   <= '0;
          rd_ptr_q <= rd_ptr_q + QW'(1);
          state_q  <= RD_IDLE;
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  asymm_bram_min_rd #(
    .MIN_WIDTH (OUT_WIDTH),
    .RATIO     (RATIO),
    .MAX_DEPTH (1 << (QW + AW))
  ) u_bram (
    .clk_i     (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i ({wr_ptr_q, wr_addr}),
    .din_i     (din),
    .rd_en_i   (1'b1),
    .rd_addr_i ({rd_ptr_q, slice_q[AW+RSH-1:0]}),
    .dout_o    (bram_q)
  );

  assign ready  = ready_q;
  assign full   = full_q;
  assign n_free = n_free_q;
  assign dout   = dout_q;
  assign empty  = empty_q;

endmodule

// File: tb/tb_uob_pq.sv
// Directed bench for uob_pq: table of packets with hand-computed byte streams,
// plus sequences for fill/full, abort, complete-during-TERM and mid-read reset.
module tb_uob_pq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [2:0]  wr_tid;
  logic        set_input_complete;
  logic        set_input_abort;
  logic        ready;
  logic        full;
  logic [3:0]  n_free;
  logic [7:0]  dout;
  logic        rd_en;
  logic        empty;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic [2:0]  tid;
    logic [2:0]  n;
    logic [63:0] words;
    logic [87:0] exp;
  } vec_t;

  vec_t vecs [4];

  uob_pq dut (
    .clk                (clk),
    .rst                (rst),
    .din                (din),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_tid             (wr_tid),
    .set_input_complete (set_input_complete),
    .set_input_abort    (set_input_abort),
    .ready              (ready),
    .full               (full),
    .n_free             (n_free),
    .dout               (dout),
    .rd_en              (rd_en),
    .empty              (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_pkt(input logic [2:0] tid, input int n, input logic [63:0] words);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      din     = words[16*i +: 16];
      wr_tid  = tid;
      tick();
    end
    wr_en              = 1'b0;
    set_input_complete = 1'b1;
    wr_tid             = tid;
    tick();
    set_input_complete = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0] tid, input int n, input logic [63:0] words);
    exp_q.push_back(8'hFF);
    exp_q.push_back({5'd0, tid});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(words[16*i +: 8]);
      exp_q.push_back(words[16*i+8 +: 8]);
    end
    exp_q.push_back(8'h00);
  endtask

  task automatic wait_offer(input string name);
    int waited = 0;
    while (empty && waited < 20) begin
      tick();
      waited++;
    end
    check({name, " offer"}, empty, 1'b0);
  endtask

  task automatic read_pkt(input string name, input int n_bytes,
                          input bit complete_at_term, input logic [2:0] ctid);
    logic [7:0] e;
    wait_offer(name);
    if (empty) begin
      for (int j = 0; j < n_bytes; j++) void'(exp_q.pop_front());
      return;
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int j = 0; j < n_bytes; j++) begin
      if (j > 0) tick();
      e = exp_q.pop_front();
      check($sformatf("%s byte%0d", name, j), dout, e);
      if (j == 0) check({name, " empty after rd_en"}, empty, 1'b1);
    end
    if (complete_at_term) begin
      set_input_complete = 1'b1;
      wr_tid             = ctid;
      tick();
      set_input_complete = 1'b0;
    end
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    vecs[0] = '{tid: 3'd5, n: 3'd3, words: {16'h0, 16'h9ABC, 16'h5678, 16'h1234},
                exp: {8'hFF, 8'h05, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'h00, 8'h00, 8'h00}};
    vecs[1] = '{tid: 3'd2, n: 3'd1, words: {16'h0, 16'h0, 16'h0, 16'hA55A},
                exp: {8'hFF, 8'h02, 8'h5A, 8'hA5, 8'h00, 48'h0}};
    vecs[2] = '{tid: 3'd7, n: 3'd0, words: 64'h0,
                exp: {8'hFF, 8'h07, 8'h00, 64'h0}};
    vecs[3] = '{tid: 3'd0, n: 3'd2, words: {16'h0, 16'h0, 16'h8001, 16'h00FF},
                exp: {8'hFF, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h00, 32'h0}};

    rst = 1'b1; din = '0; wr_en = 1'b0; wr_addr = '0; wr_tid = '0;
    set_input_complete = 1'b0; set_input_abort = 1'b0; rd_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset ready", ready, 1'b1);
    check("reset full", full, 1'b0);
    check("reset n_free", n_free, 4'd8);
    check("reset dout", dout, 8'h00);
    check("reset empty", empty, 1'b1);

    for (int i = 0; i < 4; i++) begin
      write_pkt(vecs[i].tid, int'(vecs[i].n), vecs[i].words);
      check($sformatf("vec%0d n_free after complete", i), n_free, 4'd7);
      check($sformatf("vec%0d empty right after complete", i), empty, 1'b1);
      for (int j = 0; j < 3 + 2 * int'(vecs[i].n); j++)
        exp_q.push_back(vecs[i].exp[87-8*j -: 8]);
      read_pkt($sformatf("vec%0d", i), 3 + 2 * int'(vecs[i].n), 1'b0, 3'd0);
      tick();
    end

    // Abort a partial packet, then send a short one.
    wr_en = 1'b1; wr_addr = 5'd0; din = 16'hDEAD; wr_tid = 3'd6;
    tick();
    check("abort ready in progress", ready, 1'b0);
    wr_addr = 5'd1; din = 16'hCAFE;
    tick();
    wr_en = 1'b0; set_input_abort = 1'b1;
    tick();
    set_input_abort = 1'b0;
    check("abort ready", ready, 1'b1);
    check("abort n_free", n_free, 4'd8);
    write_pkt(3'd2, 1, 64'h0000_0000_0000_BEEF);
    push_exp(3'd2, 1, 64'h0000_0000_0000_BEEF);
    read_pkt("abort pkt", 5, 1'b0, 3'd0);
    tick(); tick(); tick();
    check("abort single packet", empty, 1'b1);

    // Fill all slots.
    for (int i = 0; i < 8; i++) begin
      write_pkt(3'(i), 1, {48'h0, 16'hA0B0 + 16'(i) * 16'h0101});
      push_exp(3'(i), 1, {48'h0, 16'hA0B0 + 16'(i) * 16'h0101});
    end
    check("fill full", full, 1'b1);
    check("fill ready", ready, 1'b0);
    check("fill n_free", n_free, 4'd0);
    wr_en = 1'b1; wr_addr = 5'd0; din = 16'h1111; wr_tid = 3'd5;
    tick();
    wr_en = 1'b0;
    check("ignored write full", full, 1'b1);
    read_pkt("fill pkt0", 5, 1'b0, 3'd0);
    check("n_free at term", n_free, 4'd0);
    tick();
    check("n_free after term", n_free, 4'd1);
    check("ready after term", ready, 1'b1);
    check("full after term", full, 1'b0);

    write_pkt(3'd3, 1, 64'h0000_0000_0000_C3D3);
    push_exp(3'd3, 1, 64'h0000_0000_0000_C3D3);
    check("refill full", full, 1'b1);
    read_pkt("fill pkt1", 5, 1'b1, 3'd4);
    push_exp(3'd4, 0, 64'h0);
    check("complete at term full", full, 1'b1);
    check("complete at term n_free", n_free, 4'd0);
    for (int k = 0; k < 8; k++) begin
      read_pkt($sformatf("drain%0d", k), (k == 7) ? 3 : 5, 1'b0, 3'd0);
    end
    tick();
    check("drain n_free", n_free, 4'd8);
    tick(); tick();
    check("drain empty", empty, 1'b1);

    // Reset in the middle of DATA.
    write_pkt(3'd1, 3, 64'h0000_3333_2222_1111);
    wait_offer("rst pkt");
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("rst pkt hdr", dout, 8'hFF);
    tick();
    check("rst pkt tid", dout, 8'h01);
    tick();
    check("rst pkt data0", dout, 8'h11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-read rst dout", dout, 8'h00);
    check("mid-read rst empty", empty, 1'b1);
    check("mid-read rst n_free", n_free, 4'd8);
    check("mid-read rst ready", ready, 1'b1);
    tick(); tick();
    check("after rst still empty", empty, 1'b1);
    write_pkt(vecs[0].tid, int'(vecs[0].n), vecs[0].words);
    for (int j = 0; j < 9; j++) exp_q.push_back(vecs[0].exp[87-8*j -: 8]);
    read_pkt("post rst", 9, 1'b0, 3'd0);
    tick();
    check("post rst n_free", n_free, 4'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uob_pq.md
# uob_pq

Unit output buffer with a packet queue and per-packet metadata, single clock domain. It sits between a unit's CPU (16-bit write side) and the unit-to-arbiter output bus (narrow read side). Each packet carries its own length and thread ID, a partially written packet can be aborted, and a synchronous reset returns the whole queue to empty.

## Interface
- IN_WIDTH, 16: write word width.
- OUT_WIDTH, 8: read word width; RATIO = IN_WIDTH/OUT_WIDTH, a power of 2 and at least 1.
- MAX_PKT_LEN, 20: maximum packet length in input words.
- ADDR_MSB, `MSB(MAX_PKT_LEN-1)`: MSB of wr_addr.
- PKT_QUEUE_MSB, 2: 2^(PKT_QUEUE_MSB+1) slots. All slots are usable.
- N_THREADS, `N_THREADS`: thread count. Requires `MSB(N_THREADS-1)` < OUT_WIDTH.
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- din  in  IN_WIDTH  write data.
- wr_en  in  1  write din at wr_addr of the current write slot.
- wr_addr  in  ADDR_MSB+1  word address within the packet.
- wr_tid  in  `MSB(N_THREADS-1)`+1  thread ID, sampled on the first accepted wr_en of a packet.
- set_input_complete  in  1  enqueue the current packet.
- set_input_abort  in  1  discard the current packet.
- ready  out  1  no packet in progress and a free slot exists. Reset value 1.
- full  out  1  all slots are occupied. Reset value 0.
- n_free  out  PKT_QUEUE_MSB+2  number of free slots. Reset value 2^(PKT_QUEUE_MSB+1).
- dout  out  OUT_WIDTH  output bus. Reset value 0.
- rd_en  in  1  start reading the head packet. Only sampled while empty=0.
- empty  out  1  no packet is offered. Reset value 1.

## Operation
- Write side:
  - An accepted wr_en (full=0) sets in_progress. If in_progress was 0, it also latches wr_tid.
  - The slot length tracks max(wr_addr)+1 over all accepted writes.
  - wr_en while full=1 is ignored.
  - wr_addr ≥ MAX_PKT_LEN is a caller error; the behaviour is undefined.
- set_input_complete while full=0:
  - Stores tid and length for the slot, advances wr_ptr and increments count.
  - Clears in_progress and the length tracker.
  - A complete with no writes enqueues a length-0 packet.
- set_input_abort clears in_progress and the length tracker. wr_ptr and count are unchanged. If abort and complete are asserted in the same cycle, abort wins.
- ready = ~in_progress & (count < DEPTH). full = (count == DEPTH). n_free = DEPTH - count. All three are registered.
- Read FSM states: IDLE, OFFER, HDR, TID, DATA, TERM.
  - IDLE → OFFER when count > 0; empty deasserts.
  - OFFER: rd_en → HDR; empty asserts.
  - HDR: dout = all-ones → TID.
  - TID: dout = zero-extended tid → DATA, or → TERM if len = 0.
  - DATA: dout = next OUT_WIDTH slice. Within each input word, the LS slice comes first. Emits len*RATIO words, then → TERM.
  - TERM: dout = 0; rd_ptr+1; count-1 → IDLE.
- Enqueue and the TERM pop in the same cycle leave count unchanged.
- Pointers are PKT_QUEUE_MSB+1 bits and wrap modulo DEPTH. count is one bit wider.
- rst clears:
  - write side: pointers, count and in_progress;
  - read side: the FSM (to IDLE), dout and empty.
  - Outputs take their reset values on the cycle after rst, including mid-read and mid-write. Memory contents are not cleared.

## Timing
- Write side:
  - An accepted wr_en is visible to a later read of the same packet. The earliest read is after complete.
  - set_input_complete at edge t: count, n_free, full and ready update at t+1. Empty deasserts at t+2 at the earliest (IDLE→OFFER).
- Read side:
  - rd_en sampled at edge t: empty=1 and dout=all-ones from t+1; tid at t+2; data word k at t+3+k; 0 at t+3+len*RATIO.
  - The slot is freed at that same edge (t+3+len*RATIO), and n_free rises one cycle later.
  - Earliest empty=0 for the next packet: two cycles after the TERM word.
- The BRAM has 1-cycle read latency. The read address must be issued one state ahead so that DATA output has no bubbles.

## Structure
- The shared header (`sha256.vh`) gains `UOB_PQ_HDR` (the all-ones marker) and `UOB_PQ_QUEUE_MSB`.
- Memory is one instance of the existing asymm_bram_min_rd:
  - write address {wr_ptr, wr_addr}, read address {rd_ptr, slice counter};
  - maxDEPTH = 2^(PKT_QUEUE_MSB+1+ADDR_MSB+1).
- Per-slot tid and length are held in small distributed register arrays. There is no other sub-module.

## Test plan
- Reset, then write 3 words (tid=5, addrs 0..2, din 0x1234/0x5678/0x9ABC), complete, rd_en → dout FF, 05, 34, 12, 78, 56, BC, 9A, 00.
- Fill all 8 slots → full=1, ready=0, n_free=0. A 9th wr_en is ignored. One read → n_free=1 one cycle after TERM.
- Write 2 words, abort, write 1 word with tid=2, complete → only one packet is emitted: FF, 02, 2 data bytes, 00.
- Complete with no writes → FF, tid, 00; the slot is freed.
- Complete in the same cycle as TERM with count=8 → count stays 8 and full stays 1.
- Assert rst during DATA → next cycle dout=0, empty=1, n_free=8; the following packet is emitted correctly.
